// File: rtl/mem_wait_responder.sv
// mem_wait_responder
//   Word-addressed data/instruction memory with a request/response handshake.
//   A request is accepted only in IDLE. Reads respond READ_LAT edges after
//   acceptance. Writes commit and acknowledge WRITE_LAT edges after acceptance.
//   Misaligned requests go straight to RESPOND with misaligned_err set, and
//   they never touch the array.
//
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous, active-high
//   req_valid       request present
//   req_write       1 = write, 0 = read
//   req_addr        byte address (word index = req_addr[ADDR_WIDTH+1:2])
//   req_wdata       write data
//   req_ready       can accept a request this cycle (state == IDLE)
//   resp_valid      one-cycle response/ack pulse
//   resp_rdata      read data, updated only by successful reads
//   misaligned_err  qualifies resp_valid: the access was rejected
//   busy            high in every state except IDLE
//   state_out       IDLE=0, READ_WAIT=1, WRITE_WAIT=2, RESPOND=3
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready, waiting for req_valid
// READ_WAIT  | counting read wait states; array is read when counter==0
// WRITE_WAIT | counting write wait states; array is written when counter==0
// RESPOND    | resp_valid pulse; unconditionally returns to IDLE
module mem_wait_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 2,
  parameter int WRITE_LAT  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  misaligned_err,
  output logic                  busy,
  output logic [1:0]            state_out
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RESPOND    = 2'd3
  } state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] READ_INIT  = 4'(READ_LAT - 1);
  localparam logic [3:0] WRITE_INIT = 4'(WRITE_LAT - 1);

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    mis_q;
  logic                    accept;
  logic                    misaligned;
  logic                    do_read;
  logic                    do_write;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  // Upper address bits are ignored on purpose: addresses alias modulo the depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESPOND);
  assign misaligned_err = resp_valid & mis_q;
  assign busy           = (state != IDLE);
  assign state_out      = state;
  assign accept         = req_valid & req_ready;
  assign misaligned     = (req_addr[1:0] != 2'b00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_read   = 1'b0;
    do_write  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_nxt = RESPOND;
          end else if (req_write) begin
            state_nxt = WRITE_WAIT;
            cnt_nxt   = WRITE_INIT;
          end else begin
            state_nxt = READ_WAIT;
            cnt_nxt   = READ_INIT;
          end
        end
      end
      READ_WAIT: begin
        if (cnt == 4'd0) begin
          do_read   = 1'b1;
          state_nxt = RESPOND;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WRITE_WAIT: begin
        if (cnt == 4'd0) begin
          do_write  = 1'b1;
          state_nxt = RESPOND;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESPOND: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch the request at acceptance. Later input changes are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= req_addr[ADDR_WIDTH+1:2];
      wdata_q <= req_wdata;
      mis_q   <= misaligned;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_rdata <= '0;
    end else if (do_read) begin
      resp_rdata <= mem[idx_q];
    end
  end

  // The array is not reset. Reset forces IDLE, so an aborted write never commits.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule
